window_5x5_gen: RTL and testbench

Sliding-window assembler sitting directly downstream of the 5-row line buffer in the LeNet convolution path. Each accepted cycle it takes one 5-pixel vertical column (top = oldest row) and shifts it into a 5×5 register window. It tracks column and row position for the active feature-map size. It flags only windows that lie fully inside the map, i.e. "valid" convolution positions, and hands them to the MAC array.

---
 rtl/lenet_pkg.sv | 31 +++
 rtl/window_5x5_gen_if.sv | 32 +++
 rtl/fmap_width_dec.sv | 28 ++
 rtl/window_5x5_gen.sv | 166 ++++++++++++++++
 tb/tb_window_5x5_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet convolution-path definitions: feature-map sizes, mode codes,
// window geometry and the window element index helper.
package lenet_pkg;

    localparam int unsigned WIN_K = 5;

    localparam int unsigned FEATURE_MAP1_SIZE = 32;
    localparam int unsigned FEATURE_MAP2_SIZE = 28;
    localparam int unsigned FEATURE_MAP3_SIZE = 14;
    localparam int unsigned FEATURE_MAP4_SIZE = 10;
    localparam int unsigned FEATURE_MAP5_SIZE = 5;

    typedef enum logic [2:0] {
        MODE_FM1 = 3'b000,
        MODE_FM2 = 3'b001,
        MODE_FM3 = 3'b010,
        MODE_FM4 = 3'b011,
        MODE_FM5 = 3'b100
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } win_state_e;

    // Flat index of window element (r,c); r=0 is the top row, c=0 the oldest column.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * WIN_K + c;
    endfunction

endpackage

// File: rtl/window_5x5_gen_if.sv
// Column-in / window-out bundle between the line buffer, the window
// assembler and the MAC array.
interface window_5x5_gen_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_WIDTH  = 32,
    parameter int unsigned CW         = $clog2(MAX_WIDTH)
);
    logic [2:0]               mode;
    logic                     clear;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    col_0;
    logic [DATA_WIDTH-1:0]    col_1;
    logic [DATA_WIDTH-1:0]    col_2;
    logic [DATA_WIDTH-1:0]    col_3;
    logic [DATA_WIDTH-1:0]    col_4;

    logic [25*DATA_WIDTH-1:0] win_data;
    logic                     win_valid;
    logic [CW-1:0]            win_row;
    logic [CW-1:0]            win_col;
    logic                     frame_done;

    modport master (
        output mode, clear, in_valid, col_0, col_1, col_2, col_3, col_4,
        input  win_data, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  mode, clear, in_valid, col_0, col_1, col_2, col_3, col_4,
        output win_data, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/fmap_width_dec.sv
// Mode to feature-map side decoder, shared with the line buffer so both
// blocks always agree on the active width.
module fmap_width_dec #(
    parameter int unsigned MAX_WIDTH         = 32,
    parameter int unsigned WW                = $clog2(MAX_WIDTH + 1),
    parameter int unsigned FEATURE_MAP1_SIZE = lenet_pkg::FEATURE_MAP1_SIZE,
    parameter int unsigned FEATURE_MAP2_SIZE = lenet_pkg::FEATURE_MAP2_SIZE,
    parameter int unsigned FEATURE_MAP3_SIZE = lenet_pkg::FEATURE_MAP3_SIZE,
    parameter int unsigned FEATURE_MAP4_SIZE = lenet_pkg::FEATURE_MAP4_SIZE,
    parameter int unsigned FEATURE_MAP5_SIZE = lenet_pkg::FEATURE_MAP5_SIZE
) (
    input  logic [2:0]    mode,
    output logic [WW-1:0] width
);
    import lenet_pkg::*;

    always_comb begin
        width = WW'(FEATURE_MAP1_SIZE);
        case (mode)
            MODE_FM1: width = WW'(FEATURE_MAP1_SIZE);
            MODE_FM2: width = WW'(FEATURE_MAP2_SIZE);
            MODE_FM3: width = WW'(FEATURE_MAP3_SIZE);
            MODE_FM4: width = WW'(FEATURE_MAP4_SIZE);
            MODE_FM5: width = WW'(FEATURE_MAP5_SIZE);
            default:  width = WW'(FEATURE_MAP1_SIZE);
        endcase
    end
endmodule

// File: rtl/window_5x5_gen.sv
// 5x5 sliding-window assembler: shifts one vertical column per accepted cycle
// into a register window and flags windows lying fully inside the feature map.
module window_5x5_gen #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned MAX_WIDTH         = 32,
    parameter int unsigned FEATURE_MAP1_SIZE = lenet_pkg::FEATURE_MAP1_SIZE,
    parameter int unsigned FEATURE_MAP2_SIZE = lenet_pkg::FEATURE_MAP2_SIZE,
    parameter int unsigned FEATURE_MAP3_SIZE = lenet_pkg::FEATURE_MAP3_SIZE,
    parameter int unsigned FEATURE_MAP4_SIZE = lenet_pkg::FEATURE_MAP4_SIZE,
    parameter int unsigned FEATURE_MAP5_SIZE = lenet_pkg::FEATURE_MAP5_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    window_5x5_gen_if.slave   bus
);
    import lenet_pkg::*;

    localparam int unsigned CW = $clog2(MAX_WIDTH);
    localparam int unsigned WW = $clog2(MAX_WIDTH + 1);

    win_state_e            state;
    win_state_e            state_nx;

    logic [CW-1:0]         col_cnt;
    logic [CW-1:0]         row_cnt;
    logic [WW-1:0]         act_w;
    logic [WW-1:0]         dec_w;
    logic [WW-1:0]         cur_w;

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  in_map;

    logic [DATA_WIDTH-1:0] win [WIN_K][WIN_K];
    logic [DATA_WIDTH-1:0] col_in [WIN_K];

    logic                  win_valid_q;
    logic                  frame_done_q;
    logic [CW-1:0]         win_row_q;
    logic [CW-1:0]         win_col_q;

    fmap_width_dec #(
        .MAX_WIDTH        (MAX_WIDTH),
        .WW               (WW),
        .FEATURE_MAP1_SIZE(FEATURE_MAP1_SIZE),
        .FEATURE_MAP2_SIZE(FEATURE_MAP2_SIZE),
        .FEATURE_MAP3_SIZE(FEATURE_MAP3_SIZE),
        .FEATURE_MAP4_SIZE(FEATURE_MAP4_SIZE),
        .FEATURE_MAP5_SIZE(FEATURE_MAP5_SIZE)
    ) u_width_dec (
        .mode (bus.mode),
        .width(dec_w)
    );

    always_comb begin
        col_in[0] = bus.col_0;
        col_in[1] = bus.col_1;
        col_in[2] = bus.col_2;
        col_in[3] = bus.col_3;
        col_in[4] = bus.col_4;
    end

    // The first column of a frame is compared against the freshly decoded width,
    // so the wrap logic never has to wait for act_w to load.
    always_comb begin
        accept   = bus.in_valid && !bus.clear;
        cur_w    = (state == ST_IDLE) ? dec_w : act_w;
        col_last = (WW'(col_cnt) == cur_w - WW'(1));
        row_last = (WW'(row_cnt) == cur_w - WW'(1));
        in_map   = (row_cnt >= CW'(WIN_K - 1)) && (col_cnt >= CW'(WIN_K - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear || (accept && col_last && row_last)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            act_w        <= WW'(FEATURE_MAP1_SIZE);
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else if (bus.clear) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                act_w <= dec_w;
            end
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + CW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
            win_valid_q  <= in_map;
            frame_done_q <= in_map && col_last && row_last;
            if (in_map) begin
                win_row_q <= row_cnt - CW'(WIN_K - 1);
                win_col_q <= col_cnt - CW'(WIN_K - 1);
            end
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < WIN_K; r++) begin
                for (int unsigned c = 0; c < WIN_K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned r = 0; r < WIN_K; r++) begin
                for (int unsigned c = 0; c < WIN_K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][WIN_K-1] <= col_in[r];
            end
        end
    end

    always_comb begin
        bus.win_data = '0;
        for (int unsigned r = 0; r < WIN_K; r++) begin
            for (int unsigned c = 0; c < WIN_K; c++) begin
                bus.win_data[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Scoreboard bench for window_5x5_gen: the driver queues the expected window for
// every in-map column, a negedge monitor pops and compares each presented window.
module tb_window_5x5_gen;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXW = 32;
    localparam int unsigned CW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_5x5_gen_if #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW)) bus ();

    window_5x5_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int               row;
        int               col;
        logic [25*DW-1:0] data;
        logic             fd;
    } exp_t;

    typedef struct {
        int               acc;
        int               row;
        int               col;
        logic [25*DW-1:0] data;
        logic             fd;
    } obs_t;

    exp_t expq[$];
    obs_t obs[$];
    exp_t e;
    int   checks   = 0;
    int   errors   = 0;
    int   mon_acc  = 0;
    logic prev_acc = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int y, input int x);
        int v;
        v = y * 16 + x;
        return v[7:0];
    endfunction

    function automatic logic [25*DW-1:0] exp_win(input int wr, input int wc);
        logic [25*DW-1:0] d;
        d = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                d[(r*5+c)*DW +: DW] = pix(wr + r, wc + c);
        return d;
    endfunction

    function automatic logic [7:0] el(input logic [25*DW-1:0] d, input int r, input int c);
        return d[(r*5+c)*DW +: DW];
    endfunction

    // Monitor: counts accepted columns and checks every presented window.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) mon_acc++;
            if (bus.win_valid) begin
                obs.push_back('{mon_acc, int'(bus.win_row), int'(bus.win_col), bus.win_data, bus.frame_done});
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got row %0d col %0d expected none", bus.win_row, bus.win_col);
                end else begin
                    e = expq.pop_front();
                    chk("win_row", bus.win_row, e.row);
                    chk("win_col", bus.win_col, e.col);
                    chk("win_data", bus.win_data, e.data);
                    chk("frame_done", bus.frame_done, e.fd);
                end
            end else begin
                chk("frame_done_without_valid", bus.frame_done, 1'b0);
            end
            if (!prev_acc) chk("valid_after_idle", bus.win_valid, 1'b0);
            prev_acc = bus.in_valid && !bus.clear;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_col(input int y, input int x);
        bus.in_valid = 1'b1;
        bus.col_0 = pix(y - 4, x);
        bus.col_1 = pix(y - 3, x);
        bus.col_2 = pix(y - 2, x);
        bus.col_3 = pix(y - 1, x);
        bus.col_4 = pix(y, x);
    endtask

    task automatic run_frame(input logic [2:0] m, input int w, input int ncols, input bit stall,
                             input int sw_at, input logic [2:0] m1);
        int y, x;
        for (int k = 0; k < ncols; k++) begin
            if (k == sw_at) bus.mode = m1;
            else if (k == 0) bus.mode = m;
            if (stall && ($urandom_range(1, 0) == 1)) begin
                bus.in_valid = 1'b0;
                step();
            end
            y = k / w;
            x = k % w;
            drive_col(y, x);
            if (y >= 4 && x >= 4)
                expq.push_back('{y - 4, x - 4, exp_win(y - 4, x - 4), (y == w - 1) && (x == w - 1)});
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic settle();
        bus.in_valid = 1'b0;
        repeat (2) step();
        chk("scoreboard_drained", expq.size(), 0);
    endtask

    // Hand-computed expectations of the W=10 pattern frame.
    task automatic check_pattern(input int ob, input int ab);
        int n;
        n = obs.size() - ob;
        chk("pattern_count", n, 36);
        if (n > 0) begin
            chk("first_acc", obs[ob].acc - ab, 45);
            chk("first_pos", {obs[ob].row, obs[ob].col}, {32'd0, 32'd0});
            chk("first_00", el(obs[ob].data, 0, 0), 8'h00);
            chk("first_44", el(obs[ob].data, 4, 4), 8'h44);
            chk("last_pos", {obs[obs.size()-1].row, obs[obs.size()-1].col}, {32'd5, 32'd5});
            chk("last_44", el(obs[obs.size()-1].data, 4, 4), 8'h99);
            chk("last_fd", obs[obs.size()-1].fd, 1'b1);
            for (int i = ob; i < obs.size(); i++) begin
                if (obs[i].row == 1 && obs[i].col == 0) begin
                    chk("wrap_acc", obs[i].acc - ab, 55);
                    chk("wrap_40", el(obs[i].data, 4, 0), 8'h50);
                end
            end
        end
    endtask

    initial begin
        int ob, ab, n;
        bus.mode = 3'b000;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.col_0 = '0; bus.col_1 = '0; bus.col_2 = '0; bus.col_3 = '0; bus.col_4 = '0;

        @(negedge clk);
        chk("reset_win_data", bus.win_data, '0);
        chk("reset_flags", {bus.win_valid, bus.frame_done, bus.win_row, bus.win_col}, '0);
        step();
        rst_n = 1'b1;
        step();

        // Pattern frame, W=10
        ob = obs.size(); ab = mon_acc;
        run_frame(3'b011, 10, 100, 1'b0, -1, 3'b000);
        settle();
        check_pattern(ob, ab);

        // Same frame with random single-cycle gaps
        ob = obs.size(); ab = mon_acc;
        run_frame(3'b011, 10, 100, 1'b1, -1, 3'b000);
        settle();
        check_pattern(ob, ab);

        // Mode latched at frame start: W=5 despite switching to 000 mid-frame
        ob = obs.size(); ab = mon_acc;
        run_frame(3'b100, 5, 25, 1'b0, 3, 3'b000);
        settle();
        n = obs.size() - ob;
        chk("w5_count", n, 1);
        if (n > 0) begin
            chk("w5_acc", obs[ob].acc - ab, 25);
            chk("w5_fd", obs[ob].fd, 1'b1);
        end
        ob = obs.size();
        run_frame(3'b000, 32, 1024, 1'b0, -1, 3'b000);
        settle();
        chk("w32_count", obs.size() - ob, 784);

        // Clear collides with a column at column 50 of a W=28 frame
        ob = obs.size();
        run_frame(3'b001, 28, 49, 1'b0, -1, 3'b000);
        bus.clear = 1'b1;
        drive_col(1, 21);
        step();
        bus.clear = 1'b0;
        run_frame(3'b001, 28, 784, 1'b0, -1, 3'b000);
        settle();
        chk("w28_count", obs.size() - ob, 576);

        // Async reset mid-frame, then a fresh pattern frame
        run_frame(3'b011, 10, 50, 1'b0, -1, 3'b000);
        settle();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midreset_win_data", bus.win_data, '0);
            chk("midreset_flags", {bus.win_valid, bus.frame_done, bus.win_row, bus.win_col}, '0);
        end
        step();
        rst_n = 1'b1;
        step();
        ob = obs.size(); ab = mon_acc;
        run_frame(3'b011, 10, 100, 1'b0, -1, 3'b000);
        settle();
        check_pattern(ob, ab);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
